// File: rtl/tpu_pp_pkg.sv
// Shared types and constants for the systolic-array result post-processor.
// State encoding, tile geometry, register map and STATUS layout live here.
package tpu_pp_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    PROCESS = 2'd1,
    DONE    = 2'd2
  } pp_state_e;

  localparam int ARRAY_SIZE = 3;
  localparam int TILE_N     = ARRAY_SIZE * ARRAY_SIZE;
  localparam int N_WORDS    = 3;

  localparam logic [3:0] OFS_STATUS = 4'h0;
  localparam logic [3:0] OFS_WORD0  = 4'h4;
  localparam logic [3:0] OFS_WORD1  = 4'h8;
  localparam logic [3:0] OFS_WORD2  = 4'hC;

  localparam int ST_DONE_BIT = 0;
  localparam int ST_SAT_BIT  = 1;
  localparam int ST_OVR_BIT  = 2;
  localparam int ST_CNT_LSB  = 4;

  function automatic logic [3:0] tile_idx(logic [1:0] row, int col);
    return 4'(row) * 4'(ARRAY_SIZE) + 4'(col);
  endfunction

  function automatic logic [31:0] pack_status(logic done, logic sat, logic ovr,
                                              logic [3:0] total);
    logic [31:0] s;
    s = '0;
    s[ST_DONE_BIT]      = done;
    s[ST_SAT_BIT]       = sat;
    s[ST_OVR_BIT]       = ovr;
    s[ST_CNT_LSB +: 4]  = total;
    return s;
  endfunction

endpackage

// File: rtl/tpu_result_pp_if.sv
// Column result streams from the array plus the Caravel Wishbone slave port.
// The array side is the master of the columns; Caravel is the Wishbone master.
interface tpu_result_pp_if
  import tpu_pp_pkg::*;
#(
  parameter int ACC_W = 16
) ();

  logic [ARRAY_SIZE-1:0]       col_valid;
  logic [ARRAY_SIZE*ACC_W-1:0] col_data;
  logic                        in_ready;
  logic                        tile_done;

  logic        caravel_wb_stb_i;
  logic        caravel_wb_cyc_i;
  logic        caravel_wb_we_i;
  logic [3:0]  caravel_wb_sel_i;
  logic [31:0] caravel_wb_adr_i;
  logic [31:0] caravel_wb_dat_i;
  logic        caravel_wb_ack_o;
  logic [31:0] caravel_wb_dat_o;

  modport slave (
    input  col_valid, col_data,
    input  caravel_wb_stb_i, caravel_wb_cyc_i, caravel_wb_we_i,
    input  caravel_wb_sel_i, caravel_wb_adr_i, caravel_wb_dat_i,
    output in_ready, tile_done,
    output caravel_wb_ack_o, caravel_wb_dat_o
  );

  modport master (
    output col_valid, col_data,
    output caravel_wb_stb_i, caravel_wb_cyc_i, caravel_wb_we_i,
    output caravel_wb_sel_i, caravel_wb_adr_i, caravel_wb_dat_i,
    input  in_ready, tile_done,
    input  caravel_wb_ack_o, caravel_wb_dat_o
  );

endinterface

// File: rtl/tpu_pp_act.sv
// Combinational activation, arithmetic shift and unsigned 8-bit saturation of one element.
// Optional threshold ReLU is enabled by defining TPU_PP_RELU_EN.
module tpu_pp_act #(
  parameter int ACC_W     = 16,
  parameter int THRESHOLD = 2,
  parameter int SHIFT     = 0
) (
  input  logic signed [ACC_W-1:0] val_i,
  output logic        [7:0]       res_o,
  output logic                    sat_o
);

  localparam logic signed [ACC_W-1:0] MAX_U8 = ACC_W'(255);
`ifdef TPU_PP_RELU_EN
  localparam logic signed [ACC_W-1:0] THR = ACC_W'(THRESHOLD);
`endif

  logic signed [ACC_W-1:0] act_v;
  logic signed [ACC_W-1:0] shf_v;

  always_comb begin
`ifdef TPU_PP_RELU_EN
    act_v = (val_i < THR) ? '0 : val_i;
`else
    act_v = val_i;
`endif
    shf_v = act_v >>> SHIFT;
    res_o = 8'h00;
    sat_o = 1'b0;
    // Negative results clamp silently; only the high side counts as saturation.
    if (shf_v[ACC_W-1]) begin
      res_o = 8'h00;
    end else if (shf_v > MAX_U8) begin
      res_o = 8'hFF;
      sat_o = 1'b1;
    end else begin
      res_o = shf_v[7:0];
    end
  end

endmodule

// File: rtl/tpu_result_pp.sv
// Deskews three skewed column streams into a 3x3 tile, post-processes it in 9 cycles, exposes 3 packed words over Wishbone.
// in_ready is low outside COLLECT; Wishbone acks one cycle after request. Optional ReLU: TPU_PP_RELU_EN.
module tpu_result_pp
  import tpu_pp_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h3000_0010,
  parameter int          ACC_W        = 16,
  parameter int          THRESHOLD    = 2,
  parameter int          SHIFT        = 0
) (
  input logic             caravel_wb_clk_i,
  input logic             caravel_wb_rst_i,
  tpu_result_pp_if.slave  bus
);

  pp_state_e        state_q, state_d;
  logic [ACC_W-1:0] tile_q [TILE_N];
  logic [ACC_W-1:0] tile_d [TILE_N];
  logic [1:0]       cnt_q  [ARRAY_SIZE];
  logic [1:0]       cnt_d  [ARRAY_SIZE];
  logic [31:0]      word_q [N_WORDS];
  logic [31:0]      word_d [N_WORDS];
  logic [3:0]       p_q, p_d;
  logic             sat_q, sat_d;
  logic             ovr_q, ovr_d;
  logic             ack_q, ack_d;
  logic [31:0]      dat_q, dat_d;

  logic [3:0]  total;
  logic        all_held;
  logic [7:0]  act_res;
  logic        act_sat;
  logic [31:0] ofs_full;
  logic [3:0]  ofs;
  logic        hit;
  logic        req;
  logic        clr;
  logic [31:0] rdata;
  logic        unused_sig;

  assign total    = 4'(cnt_q[0]) + 4'(cnt_q[1]) + 4'(cnt_q[2]);
  assign all_held = (total == 4'(TILE_N));

  tpu_pp_act #(
    .ACC_W     (ACC_W),
    .THRESHOLD (THRESHOLD),
    .SHIFT     (SHIFT)
  ) u_act (
    .val_i (tile_q[p_q]),
    .res_o (act_res),
    .sat_o (act_sat)
  );

  assign ofs_full = bus.caravel_wb_adr_i - BASE_ADDRESS;
  assign ofs      = ofs_full[3:0];
  assign hit      = (bus.caravel_wb_adr_i >= BASE_ADDRESS) &&
                    (bus.caravel_wb_adr_i <= BASE_ADDRESS + 32'hC) &&
                    (bus.caravel_wb_adr_i[1:0] == 2'b00);
  assign req      = bus.caravel_wb_stb_i & bus.caravel_wb_cyc_i & hit;
  assign ack_d    = req & ~ack_q;
  assign clr      = ack_d & bus.caravel_wb_we_i & (ofs == OFS_STATUS) &
                    bus.caravel_wb_dat_i[0];

  assign unused_sig = ^{bus.caravel_wb_sel_i, bus.caravel_wb_dat_i[31:1], ofs_full[31:4]};

  always_comb begin
    rdata = '0;
    case (ofs)
      OFS_STATUS: rdata = pack_status(state_q == DONE, sat_q, ovr_q, total);
      OFS_WORD0:  if (state_q == DONE) rdata = word_q[0];
      OFS_WORD1:  if (state_q == DONE) rdata = word_q[1];
      OFS_WORD2:  if (state_q == DONE) rdata = word_q[2];
      default:    rdata = '0;
    endcase
  end

  assign dat_d = ack_d ? rdata : dat_q;

  always_comb begin
    state_d = state_q;
    tile_d  = tile_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    p_d     = p_q;
    sat_d   = sat_q;
    ovr_d   = ovr_q;
    case (state_q)
      COLLECT: begin
        for (int k = 0; k < ARRAY_SIZE; k++) begin
          if (bus.col_valid[k]) begin
            if (cnt_q[k] == 2'd3) begin
              ovr_d = 1'b1;
            end else begin
              tile_d[tile_idx(cnt_q[k], k)] = bus.col_data[k*ACC_W +: ACC_W];
              cnt_d[k] = cnt_q[k] + 2'd1;
            end
          end
        end
        if (all_held) state_d = PROCESS;
      end
      PROCESS: begin
        // Byte p of the tile lands LSB-first in word p/4.
        word_d[p_q[3:2]][{p_q[1:0], 3'b000} +: 8] = act_res;
        sat_d = sat_q | act_sat;
        if (p_q == 4'(TILE_N - 1)) begin
          p_d     = '0;
          state_d = DONE;
        end else begin
          p_d = p_q + 4'd1;
        end
      end
      DONE: begin
      end
      default: state_d = COLLECT;
    endcase
    // A clear wins over anything the datapath wanted to do this cycle.
    if (clr) begin
      state_d = COLLECT;
      tile_d  = '{default: '0};
      cnt_d   = '{default: '0};
      word_d  = '{default: '0};
      p_d     = '0;
      sat_d   = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge caravel_wb_clk_i) begin
    if (caravel_wb_rst_i) begin
      state_q <= COLLECT;
      tile_q  <= '{default: '0};
      cnt_q   <= '{default: '0};
      word_q  <= '{default: '0};
      p_q     <= '0;
      sat_q   <= 1'b0;
      ovr_q   <= 1'b0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      tile_q  <= tile_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      p_q     <= p_d;
      sat_q   <= sat_d;
      ovr_q   <= ovr_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
    end
  end

  assign bus.in_ready         = (state_q == COLLECT);
  assign bus.tile_done        = (state_q == DONE);
  assign bus.caravel_wb_ack_o = ack_q;
  assign bus.caravel_wb_dat_o = dat_q;

endmodule

// File: tb/tb_tpu_result_pp.sv
// Directed plus random bench for tpu_result_pp; two instances (SHIFT=0 and SHIFT=4) share one stimulus.
module tb_tpu_result_pp;

  localparam logic [31:0] BASE = 32'h3000_0010;
  localparam int          THR  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tpu_result_pp_if #(.ACC_W(16)) if0 ();
  tpu_result_pp_if #(.ACC_W(16)) if4 ();

  tpu_result_pp #(.BASE_ADDRESS(BASE), .ACC_W(16), .THRESHOLD(THR), .SHIFT(0)) dut0 (
    .caravel_wb_clk_i (clk),
    .caravel_wb_rst_i (rst),
    .bus              (if0.slave)
  );

  tpu_result_pp #(.BASE_ADDRESS(BASE), .ACC_W(16), .THRESHOLD(THR), .SHIFT(4)) dut4 (
    .caravel_wb_clk_i (clk),
    .caravel_wb_rst_i (rst),
    .bus              (if4.slave)
  );

  int total_cnt = 0;
  int bad_cnt   = 0;

  // Reference model: tile contents as signed integers, per-column fill counts, flags.
  int m_tile [9];
  int m_cnt  [3];
  bit m_ovr;
  bit m_collect;
  bit m_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) else begin
      bad_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int m_total();
    return m_cnt[0] + m_cnt[1] + m_cnt[2];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 9; i++) m_tile[i] = 0;
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    m_ovr = 0; m_collect = 1; m_done = 0;
  endtask

  function automatic int act_shift(input int v, input int sh);
    int a;
    a = v;
`ifdef TPU_PP_RELU_EN
    if (v < THR) a = 0;
`endif
    return a >>> sh;
  endfunction

  function automatic logic [7:0] exp_byte(input int v, input int sh);
    int s;
    s = act_shift(v, sh);
    if (s < 0) return 8'h00;
    if (s > 255) return 8'hFF;
    return 8'(s);
  endfunction

  function automatic logic [31:0] exp_word(input int wi, input int sh);
    logic [31:0] w;
    w = '0;
    if (!m_done) return w;
    for (int b = 0; b < 4; b++)
      if (wi * 4 + b < 9) w[8*b +: 8] = exp_byte(m_tile[wi*4+b], sh);
    return w;
  endfunction

  function automatic logic [31:0] exp_status(input int sh);
    logic [31:0] s;
    bit sat;
    sat = 0;
    if (m_done)
      for (int i = 0; i < 9; i++) if (act_shift(m_tile[i], sh) > 255) sat = 1;
    s = '0;
    s[0] = m_done;
    s[1] = sat;
    s[2] = m_ovr;
    s[7:4] = 4'(m_total());
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wb(input logic stb, input logic we, input logic [31:0] adr, input logic [31:0] dat);
    if0.caravel_wb_stb_i = stb; if4.caravel_wb_stb_i = stb;
    if0.caravel_wb_cyc_i = stb; if4.caravel_wb_cyc_i = stb;
    if0.caravel_wb_we_i  = we;  if4.caravel_wb_we_i  = we;
    if0.caravel_wb_adr_i = adr; if4.caravel_wb_adr_i = adr;
    if0.caravel_wb_dat_i = dat; if4.caravel_wb_dat_i = dat;
  endtask

  task automatic cols(input logic [2:0] v, input logic [47:0] d);
    bit was_full;
    was_full = (m_total() == 9);
    if0.col_valid = v; if4.col_valid = v;
    if0.col_data  = d; if4.col_data  = d;
    tick();
    if (m_collect) begin
      for (int k = 0; k < 3; k++) begin
        if (v[k]) begin
          if (m_cnt[k] < 3) begin
            m_tile[m_cnt[k]*3 + k] = int'($signed(d[k*16 +: 16]));
            m_cnt[k]++;
          end else begin
            m_ovr = 1;
          end
        end
      end
      if (was_full) m_collect = 0;
    end
    if0.col_valid = '0; if4.col_valid = '0;
  endtask

  task automatic wb(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                    output logic [31:0] r0, output logic [31:0] r4);
    int n;
    bit acked;
    n = 0;
    set_wb(1'b1, we, adr, dat);
    do begin
      tick();
      n++;
    end while (if0.caravel_wb_ack_o !== 1'b1 && n < 4);
    acked = (if0.caravel_wb_ack_o === 1'b1);
    check("wb_ack", {31'b0, if0.caravel_wb_ack_o}, 32'd1);
    r0 = if0.caravel_wb_dat_o;
    r4 = if4.caravel_wb_dat_o;
    set_wb(1'b0, 1'b0, '0, '0);
    if (acked && we && adr == BASE && dat[0]) model_clear();
    tick();
  endtask

  task automatic clear_cmd();
    logic [31:0] r0, r4;
    wb(BASE, 1'b1, 32'h1, r0, r4);
  endtask

  task automatic check_regs(input string tag);
    logic [31:0] r0, r4;
    wb(BASE, 1'b0, '0, r0, r4);
    check({tag, "_status_s0"}, r0, exp_status(0));
    check({tag, "_status_s4"}, r4, exp_status(4));
    for (int i = 0; i < 3; i++) begin
      wb(BASE + 32'(4 * (i + 1)), 1'b0, '0, r0, r4);
      check({tag, "_word_s0"}, r0, exp_word(i, 0));
      check({tag, "_word_s4"}, r4, exp_word(i, 4));
    end
  endtask

  // Call right after the edge of the 9th accept: done must rise 10 edges later.
  task automatic wait_done(input string tag);
    int n;
    n = 0;
    tick();
    n++;
    m_collect = 0;
    check({tag, "_in_ready_low"}, {31'b0, if0.in_ready}, 32'd0);
    while (if0.tile_done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_done_latency"}, n, 32'd10);
    check({tag, "_done_s4"}, {31'b0, if4.tile_done}, 32'd1);
    m_done = 1;
  endtask

  function automatic logic [15:0] rnd_val();
    if ($urandom_range(0, 3) == 0) return 16'($urandom);
    return 16'($urandom_range(0, 400));
  endfunction

  task automatic fill_random();
    logic [47:0] d;
    for (int c = 0; c < 60 && m_total() < 9; c++) begin
      d = {rnd_val(), rnd_val(), rnd_val()};
      cols(3'($urandom_range(0, 7)), d);
    end
  endtask

  initial begin
    logic [47:0] d;
    logic [3:0]  pat;
    int          acks;
    logic [31:0] miss_adr [3];

    if0.col_valid = '0; if4.col_valid = '0;
    if0.col_data  = '0; if4.col_data  = '0;
    if0.caravel_wb_sel_i = 4'hF; if4.caravel_wb_sel_i = 4'hF;
    set_wb(1'b0, 1'b0, '0, '0);
    model_clear();

    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_in_ready", {31'b0, if0.in_ready}, 32'd1);
    check("rst_tile_done", {31'b0, if0.tile_done}, 32'd0);
    check("rst_ack", {31'b0, if0.caravel_wb_ack_o}, 32'd0);
    check("rst_dat", if0.caravel_wb_dat_o, 32'd0);
    check("rst_in_ready_s4", {31'b0, if4.in_ready}, 32'd1);
    check_regs("rst");

    // Skewed tile: column k starts k cycles late, values 1..9 row-major.
    for (int t = 0; t < 5; t++) begin
      logic [2:0] v;
      for (int k = 0; k < 3; k++) begin
        v[k] = (t >= k) && (t < k + 3);
        d[k*16 +: 16] = 16'((t - k) * 3 + k + 1);
      end
      cols(v, d);
    end
    wait_done("skew");
    check_regs("skew");
    clear_cmd();
    check("clr_done_in_ready", {31'b0, if0.in_ready}, 32'd1);
    check_regs("clr_done");

    // Saturation and negative clamp; 0x0100 >>> 4 gives 0x10 in the shifted instance.
    cols(3'b111, {16'h0100, 16'hFFFF, 16'h0200});
    cols(3'b111, {16'h0001, 16'h0002, 16'h0005});
    cols(3'b111, {16'h0030, 16'h0100, 16'h00FF});
    wait_done("sat");
    check_regs("sat");
    clear_cmd();

    // Fourth valid on column 1 is dropped and flags overrun.
    for (int i = 0; i < 4; i++) cols(3'b010, {16'h0, 16'(i + 7), 16'h0});
    check("ovr_cnt_model", 32'(m_total()), 32'd3);
    check_regs("ovr");
    clear_cmd();
    check_regs("ovr_clr");

    // Clear in the middle of PROCESS.
    fill_random();
    tick(); tick(); tick();
    clear_cmd();
    check("clr_proc_in_ready", {31'b0, if0.in_ready}, 32'd1);
    check_regs("clr_proc");

    // Held strobe: acks alternate; misses never ack.
    set_wb(1'b1, 1'b0, BASE + 32'h4, '0);
    for (int i = 0; i < 4; i++) begin
      tick();
      pat[i] = if0.caravel_wb_ack_o;
    end
    set_wb(1'b0, 1'b0, '0, '0);
    tick();
    check("held_ack_pattern", {28'b0, pat}, 32'h5);
    miss_adr[0] = BASE + 32'h20;
    miss_adr[1] = BASE + 32'h2;
    miss_adr[2] = BASE - 32'h4;
    for (int m = 0; m < 3; m++) begin
      acks = 0;
      set_wb(1'b1, 1'b0, miss_adr[m], '0);
      for (int i = 0; i < 4; i++) begin
        tick();
        if (if0.caravel_wb_ack_o === 1'b1) acks++;
      end
      set_wb(1'b0, 1'b0, '0, '0);
      tick();
      check("miss_no_ack", acks, 32'd0);
    end

    for (int r = 0; r < 3; r++) begin
      clear_cmd();
      fill_random();
      wait_done("rand");
      check_regs("rand");
    end

    // Reset mid-tile.
    clear_cmd();
    cols(3'b101, {rnd_val(), rnd_val(), rnd_val()});
    cols(3'b011, {rnd_val(), rnd_val(), rnd_val()});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    check("midrst_in_ready", {31'b0, if0.in_ready}, 32'd1);
    check("midrst_ack", {31'b0, if0.caravel_wb_ack_o}, 32'd0);
    check("midrst_dat", if0.caravel_wb_dat_o, 32'd0);
    check_regs("midrst");

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
